// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Self-test sweep for a two-input gates block. On start it drives the four (A,B)
//   combinations in order 00,01,10,11. It holds each one for SETTLE_CYCLES clocks and
//   then samples the 8-bit gate vector. Each sample is compared against a fixed truth
//   table, and the mismatching bit positions are collected into a sticky error map.
//
//   Optional feature: define CHECKER_FAIL_CAPTURE_EN to latch the index and the
//   observed vector of the first failing combination. When it is undefined, fail_idx
//   and fail_obs are tied to zero.
//
// Ports
//   clk      : system clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin a sweep (sampled only in IDLE/DONE)
//   gate_in  : [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR [6]NOT A [7]NOT B
//   a_out    : A input to the gates block
//   b_out    : B input to the gates block
//   busy     : sweep in progress
//   done     : sweep finished, result valid
//   pass     : all 32 checked bits matched (valid when done)
//   err_map  : sticky OR of mismatching bit positions
//   fail_idx : first failing combination index
//   fail_obs : gate_in observed at the first failure
module gate_truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] gate_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_map,
    output logic [1:0] fail_idx,
    output logic [7:0] fail_obs
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [7:0]       err_map_q, err_map_d;
    logic [7:0]       mismatch;

    function automatic logic [7:0] expected_vec(input logic [1:0] i);
        unique case (i)
            2'd0:    expected_vec = 8'hF8;
            2'd1:    expected_vec = 8'h4E;
            2'd2:    expected_vec = 8'h8E;
            default: expected_vec = 8'h23;
        endcase
    endfunction

    assign mismatch = gate_in ^ expected_vec(idx_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_map_d = err_map_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StDrive;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    err_map_d = 8'h00;
                    pass_d    = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    a_d       = 1'b0;
                    b_d       = 1'b0;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                err_map_d = err_map_q | mismatch;
                if (idx_q == 2'd3) begin
                    // pass must include this final sample, so use the next-state map
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_map_d == 8'h00);
                end else begin
                    state_d = StDrive;
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_map_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_map_q <= err_map_d;
        end
    end

`ifdef CHECKER_FAIL_CAPTURE_EN
    logic [1:0] fail_idx_q, fail_idx_d;
    logic [7:0] fail_obs_q, fail_obs_d;

    always_comb begin
        fail_idx_d = fail_idx_q;
        fail_obs_d = fail_obs_q;
        if ((state_q == StIdle || state_q == StDone) && start) begin
            fail_idx_d = 2'd0;
            fail_obs_d = 8'h00;
        end else if (state_q == StSample && mismatch != 8'h00 && err_map_q == 8'h00) begin
            // An empty error map means no earlier failure in this sweep
            fail_idx_d = idx_q;
            fail_obs_d = gate_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_idx_q <= 2'd0;
            fail_obs_q <= 8'h00;
        end else begin
            fail_idx_q <= fail_idx_d;
            fail_obs_q <= fail_obs_d;
        end
    end

    assign fail_idx = fail_idx_q;
    assign fail_obs = fail_obs_q;
`else
    assign fail_idx = 2'd0;
    assign fail_obs = 8'h00;
`endif

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_map = err_map_q;

endmodule
